// File: rtl/bludge_stun_manager.sv
// Per-player bludger stun/immunity sequencer. Each of the four players has an
// independent lane FSM (IDLE -> STUNNED -> CLEAR -> IMMUNE -> IDLE) and a hit counter.

module bludge_stun_lane #(
  parameter int STUN_CYCLES   = 8,
  parameter int IMMUNE_CYCLES = 16,
  parameter int BLINK_PERIOD  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game,
  input  logic       game_rise,
  input  logic       hit,
  input  logic [1:0] move_req,
  output logic       clean,
  output logic       stunned,
  output logic       blink,
  output logic [1:0] move_out,
  output logic [3:0] hit_count
);
  typedef enum logic [1:0] {IDLE, STUNNED, CLEAR, IMMUNE} state_t;

  localparam logic [7:0] STUN_LD  = 8'(STUN_CYCLES - 1);
  localparam logic [7:0] IMM_LD   = 8'(IMMUNE_CYCLES - 1);
  localparam logic [7:0] BLINK_LD = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0] CLR_LD   = 8'd3;

  state_t     state, nxt;
  logic [7:0] cnt, cnt_nxt, bcnt, bcnt_nxt;
  logic       blink_nxt;
  logic [3:0] hc_nxt;

  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    bcnt_nxt  = bcnt;
    blink_nxt = blink;
    if (!game) begin
      nxt       = IDLE;
      cnt_nxt   = '0;
      bcnt_nxt  = '0;
      blink_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          nxt     = STUNNED;
          cnt_nxt = STUN_LD;
        end
        STUNNED: if (cnt == '0) begin
          nxt     = CLEAR;
          cnt_nxt = CLR_LD;
        end else cnt_nxt = cnt - 8'd1;
        // Leave CLEAR once the flag drops, or give up after four cycles of overlap
        CLEAR: if (!hit || cnt == '0) begin
          nxt       = IMMUNE;
          cnt_nxt   = IMM_LD;
          bcnt_nxt  = BLINK_LD;
          blink_nxt = 1'b1;
        end else cnt_nxt = cnt - 8'd1;
        IMMUNE: if (cnt == '0) begin
          nxt       = IDLE;
          bcnt_nxt  = '0;
          blink_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (bcnt == '0) begin
            blink_nxt = ~blink;
            bcnt_nxt  = BLINK_LD;
          end else bcnt_nxt = bcnt - 8'd1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // A new match wipes the tally before a same-cycle hit is counted
  always_comb begin
    hc_nxt = game_rise ? 4'd0 : hit_count;
    if (game && state == IDLE && hit && hc_nxt != 4'hF) hc_nxt = hc_nxt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      blink     <= 1'b0;
      move_out  <= '0;
      hit_count <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      bcnt      <= bcnt_nxt;
      blink     <= blink_nxt;
      move_out  <= (nxt == STUNNED) ? 2'b00 : move_req;
      hit_count <= hc_nxt;
    end
  end

  assign stunned = (state == STUNNED);
  assign clean   = (state == CLEAR) || (state == IMMUNE);
endmodule

module bludge_stun_manager #(
  parameter int STUN_CYCLES   = 8,
  parameter int IMMUNE_CYCLES = 16,
  parameter int BLINK_PERIOD  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_initiated,
  input  logic [3:0]  bludged,
  input  logic [7:0]  move_req,
  output logic [3:0]  clean,
  output logic [7:0]  move_out,
  output logic [3:0]  stunned,
  output logic [3:0]  blink,
  output logic [15:0] hit_count
);
  localparam int NUM_LANES = 4;

  logic game_q;
  logic game_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) game_q <= 1'b0;
    else        game_q <= game_initiated;
  end

  assign game_rise = game_initiated & ~game_q;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    bludge_stun_lane #(
      .STUN_CYCLES  (STUN_CYCLES),
      .IMMUNE_CYCLES(IMMUNE_CYCLES),
      .BLINK_PERIOD (BLINK_PERIOD)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .game     (game_initiated),
      .game_rise(game_rise),
      .hit      (bludged[gi]),
      .move_req (move_req[2*gi +: 2]),
      .clean    (clean[gi]),
      .stunned  (stunned[gi]),
      .blink    (blink[gi]),
      .move_out (move_out[2*gi +: 2]),
      .hit_count(hit_count[4*gi +: 4])
    );
  end
endmodule

// File: tb/tb_bludge_stun_manager.sv
// Scoreboard bench for bludge_stun_manager: a phase/elapsed-time player model
// predicts each cycle's outputs, a monitor compares them one cycle later.

module tb_bludge_stun_manager;
  localparam int STUN = 8, IMM = 16, BP = 4;
  localparam int P_IDLE = 0, P_ST = 1, P_CLR = 2, P_IMM = 3;

  typedef struct packed {
    logic [3:0]  clean;
    logic [7:0]  move;
    logic [3:0]  stunned;
    logic [3:0]  blink;
    logic [15:0] hc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, game_initiated = 1'b0;
  logic [3:0]  bludged = '0;
  logic [7:0]  move_req = '0;
  logic [3:0]  clean, stunned, blink;
  logic [7:0]  move_out;
  logic [15:0] hit_count;

  bludge_stun_manager #(.STUN_CYCLES(STUN), .IMMUNE_CYCLES(IMM), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst_n(rst_n), .game_initiated(game_initiated), .bludged(bludged),
    .move_req(move_req), .clean(clean), .move_out(move_out), .stunned(stunned),
    .blink(blink), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0, fails = 0, cyc_no = 0;

  // Player model: phase + cycles spent in that phase
  int   ph[4], el[4], hc[4];
  logic gq = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin ph[i] = P_IDLE; el[i] = 0; hc[i] = 0; end
    gq = 1'b0;
  endfunction

  task automatic cyc(input logic g, input logic [3:0] b, input logic [7:0] m);
    exp_t e;
    logic rise;
    @(negedge clk);
    game_initiated = g; bludged = b; move_req = m;
    e = '0;
    if (!rst_n) model_reset();
    else begin
      rise = g && !gq;
      gq   = g;
      for (int i = 0; i < 4; i++) begin
        if (rise) hc[i] = 0;
        if (g && ph[i] == P_IDLE && b[i] && hc[i] < 15) hc[i]++;
        if (!g) begin ph[i] = P_IDLE; el[i] = 0; end
        else case (ph[i])
          P_IDLE: if (b[i]) begin ph[i] = P_ST; el[i] = 0; end
          P_ST:   if (el[i] == STUN - 1) begin ph[i] = P_CLR; el[i] = 0; end else el[i]++;
          P_CLR:  if (!b[i] || el[i] == 3) begin ph[i] = P_IMM; el[i] = 0; end else el[i]++;
          default: if (el[i] == IMM - 1) begin ph[i] = P_IDLE; el[i] = 0; end else el[i]++;
        endcase
        e.stunned[i]  = (ph[i] == P_ST);
        e.clean[i]    = (ph[i] == P_CLR) || (ph[i] == P_IMM);
        e.blink[i]    = (ph[i] == P_IMM) && ((el[i] / BP) % 2 == 0);
        e.move[2*i+:2] = (ph[i] == P_ST) ? 2'b00 : m[2*i+:2];
        e.hc[4*i+:4]  = 4'(hc[i]);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 4'b0000, 8'($urandom));
  endtask

  // Monitor: compares the prediction for the edge just taken
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk); #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{clean: clean, move: move_out, stunned: stunned, blink: blink, hc: hit_count};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL sb cyc%0d clean %b/%b move %h/%h stun %b/%b blink %b/%b hc %h/%h (act/exp)",
                   cyc_no, a.clean, e.clean, a.move, e.move, a.stunned, e.stunned,
                   a.blink, e.blink, a.hc, e.hc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s act %h exp %h", name, act, expv);
    end
  endtask

  int hold[4];

  initial begin
    logic [3:0] b;
    logic       g;
    model_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 4'b1111, 8'hFF);
    check("reset_outputs", {clean, stunned, blink, move_out, hit_count}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;

    // basic hit on player 0
    cyc(1'b1, 4'b0001, 8'($urandom));
    idle(30);
    check("basic_hc0", 32'(hit_count[3:0]), 32'd1);

    // sticky flag on player 2 held well past the CLEAR timeout
    for (int k = 0; k < 18; k++) cyc(1'b1, 4'b0100, 8'($urandom));
    idle(20);

    // simultaneous hits on players 1 and 3
    cyc(1'b1, 4'b1010, 8'($urandom));
    idle(30);

    // saturate player 3, then abort a stun with game off, then restart the match
    for (int h = 0; h < 20; h++) begin
      cyc(1'b1, 4'b1000, 8'($urandom));
      idle(26);
    end
    check("sat_hc3", 32'(hit_count[15:12]), 32'd15);
    cyc(1'b1, 4'b1000, 8'($urandom));
    idle(3);
    cyc(1'b0, 4'b0000, 8'($urandom));
    cyc(1'b0, 4'b0000, 8'($urandom));
    cyc(1'b1, 4'b0000, 8'($urandom));
    idle(2);

    // randomized traffic with sticky flags and occasional match drops
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int k = 0; k < 900; k++) begin
      g = ($urandom_range(0, 99) >= 3);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] > 0) begin hold[i]--; b[i] = 1'b1; end
        else if ($urandom_range(0, 99) < 10) begin hold[i] = $urandom_range(0, 13); b[i] = 1'b1; end
        else b[i] = 1'b0;
      end
      cyc(g, b, 8'($urandom));
    end
    idle(30);

    // asynchronous reset during player 1's immunity
    cyc(1'b1, 4'b0010, 8'($urandom));
    idle(12);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check("async_reset", {clean, stunned, blink, move_out, hit_count}, 32'h0);
    cyc(1'b1, 4'b0010, 8'($urandom));
    cyc(1'b1, 4'b0010, 8'($urandom));
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(1'b1, 4'b0010, 8'($urandom));
    idle(30);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain act %0d exp 0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
